sobel_window_gen: RTL and testbench
===================================

// Module: sobel_window_gen
// PURPOSE
//  Raster-scan 3x3 neighbourhood generator placed directly upstream of the Sobel edge operator.
//  Accepts one pixel per qualified clock and stores the two previous image rows in internal line buffers.
//  Presents the full 3x3 window as p0..p8, registered, with a valid strobe.
//  Row-major window order: p0 p1 p2 / p3 p4 p5 / p6 p7 p8, with p4 as the centre and p8 as the newest pixel.
// PARAMETERS
//  bit_width   8    pixel width in bits
//  IMG_WIDTH   640  active pixels per line; must be >= 3
//  IMG_HEIGHT  480  active lines per frame; must be >= 3
// PORTS
//  clk          in   1          pixel clock
//  rst          in   1          asynchronous, active-high reset
//  pix_valid    in   1          pix_in is qualified this cycle
//  frame_start  in   1          marks the first pixel of a frame; sampled only when pix_valid=1
//  pix_in       in   bit_width  input pixel, raster order
//  p0..p8       out  bit_width  each, 3x3 window, registered
//  win_valid    out  1          p0..p8 hold a complete in-image window
//  win_x        out  10         centre column; present only with SOBEL_WIN_COORD_EN
//  win_y        out  10         centre row; present only with SOBEL_WIN_COORD_EN
// BEHAVIOUR
//  Reset:
//   - col, row, all window registers, p0..p8, win_valid, win_x and win_y are cleared to 0.
//   - Line buffer contents are left undefined; they are never exposed (see the gating rule below).
//   - Reset applied mid-frame aborts the frame; the next accepted pixel is treated as position (0,0).
//  Accept: a pixel is accepted when pix_valid=1. When pix_valid=0, all state holds and win_valid=0 on the next cycle.
//  Position of an accepted pixel:
//   - If frame_start=1, the pixel is at (0,0).
//   - Otherwise it is at (row,col) taken from the counters.
//  Counter update after an accepted pixel:
//   - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
//   - row wraps from IMG_HEIGHT-1 to 0.
//   - frame_start=1 together with pix_valid=1 resyncs both counters at any point. The pixel is at (0,0), so the counters become col=1, row=0.
//  Line buffers: two buffers of IMG_WIDTH entries each, indexed by col.
//   - lb1 holds row r-1; lb0 holds row r-2.
//   - For each accepted pixel at column c: read lb0[c] and lb1[c], write lb0[c]<=lb1[c] and lb1[c]<=pix_in.
//   - Read and write of the same address in the same cycle return the old data (read-before-write).
//  Window shift, once per accepted pixel:
//   - Each row shifts left: p0<=p1, p1<=p2, p3<=p4, p4<=p5, p6<=p7, p7<=p8.
//   - New right column: p2<=lb0[c], p5<=lb1[c], p8<=pix_in.
//  Latency: the outputs update one clock after the accept that completes the window.
//   - win_valid=1 exactly when that accepted pixel had r>=2 and c>=2.
//   - The window centre is then at (r-1, c-1).
//  Gating: windows that would straddle a line wrap, or use rows from before row 2 or stale buffer data, always have win_valid=0.
//   - p0..p8 may still change under win_valid=0; downstream must qualify by win_valid.
//  Output count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows per frame. Border pixels produce no window.
//  No back-pressure: the consumer is purely combinational and must accept every valid window.
// CONFIGURATION
//  SOBEL_WIN_COORD_EN defined:
//   - Adds output ports win_x and win_y, registered alongside p0..p8 and reset to 0.
//   - They hold the window centre (c-1, r-1) whenever win_valid=1 and hold their last value otherwise.
//  SOBEL_WIN_COORD_EN undefined: the ports and their registers do not exist; all other behaviour is identical.
// TESTING
//  All scenarios use IMG_WIDTH=8 and IMG_HEIGHT=4. Pixel value = {row[3:0],col[3:0]}.
//  1. Stream a full frame with frame_start on pixel (0,0).
//     -> First win_valid=1 occurs one clock after accepting pixel (2,2).
//     -> p0..p8 = 00,01,02,10,11,12,20,21,22.
//     -> With SOBEL_WIN_COORD_EN: win_x=1, win_y=1.
//  2. Same frame, counting strobes.
//     -> Exactly 12 win_valid pulses.
//     -> None follows pixels with col<2 or row<2.
//     -> The last pulse shows p8=37, p4=26.
//  3. Insert pix_valid=0 bubbles of 1 to 3 cycles at random points.
//     -> Same 12 windows with identical contents and order.
//     -> win_valid=0 during every bubble.
//  4. Assert frame_start at pixel (1,5) of a running frame.
//     -> That pixel is treated as (0,0).
//     -> No win_valid until pixel (2,2) of the new frame.
//     -> Windows then match scenario 1.
//  5. Assert rst mid-row 2, then stream a new full frame.
//     -> All outputs read 0 while rst is high.
//     -> The new frame produces 12 correct windows; no stale data appears under win_valid=1.
//  6. Stream two back-to-back frames without gaps.
//     -> 24 valid windows in total.
//     -> The first window of frame 2 equals scenario 1 (wrap from row 3 to row 0 is correct).

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 raster-scan neighbourhood generator feeding the Sobel operator.
// Two line buffers hold the previous two image rows; the window is a
// 3x3 shift register updated once per accepted pixel.
// Optional feature macro: SOBEL_WIN_COORD_EN adds win_x / win_y outputs
// carrying the window centre column and row.
module sobel_window_gen #(
  parameter int bit_width  = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic                 frame_start,
  input  logic [bit_width-1:0] pix_in,
  output logic [bit_width-1:0] p0,
  output logic [bit_width-1:0] p1,
  output logic [bit_width-1:0] p2,
  output logic [bit_width-1:0] p3,
  output logic [bit_width-1:0] p4,
  output logic [bit_width-1:0] p5,
  output logic [bit_width-1:0] p6,
  output logic [bit_width-1:0] p7,
  output logic [bit_width-1:0] p8,
  output logic                 win_valid
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [9:0]           win_x,
  output logic [9:0]           win_y
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] c;
  logic [RW-1:0] r;

  logic [bit_width-1:0] lb0 [IMG_WIDTH];
  logic [bit_width-1:0] lb1 [IMG_WIDTH];
  logic [bit_width-1:0] rd0;
  logic [bit_width-1:0] rd1;
  logic                 in_image;

  // Position of the current pixel: frame_start forces (0,0); buffer reads at that column
  always_comb begin
    c        = col;
    r        = row;
    if (frame_start) begin
      c = '0;
      r = '0;
    end
    rd0      = lb0[c];
    rd1      = lb1[c];
    in_image = (r >= RW'(2)) && (c >= CW'(2));
  end

  // Raster position counters; frame_start resyncs so the next pixel is (0,1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (frame_start) begin
        col <= CW'(1);
        row <= '0;
      end else if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers: lb0 takes the row leaving lb1, lb1 takes the new pixel.
  // Reads above are combinational, so the window sees pre-write data.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0[c] <= rd1;
      lb1[c] <= pix_in;
    end
  end

  // Window shift register and valid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {p0, p1, p2, p3, p4, p5, p6, p7, p8} <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= pix_valid && in_image;
      if (pix_valid) begin
        p0 <= p1;
        p1 <= p2;
        p2 <= rd0;
        p3 <= p4;
        p4 <= p5;
        p5 <= rd1;
        p6 <= p7;
        p7 <= p8;
        p8 <= pix_in;
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  // Window centre coordinates, updated only alongside a valid window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_x <= '0;
      win_y <= '0;
    end else if (pix_valid && in_image) begin
      win_x <= 10'(c) - 10'd1;
      win_y <= 10'(r) - 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on an 8x4 image with pixel value
// {row[3:0],col[3:0]}; expected windows come from the pixel coordinates.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] pix_in = '0;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       win_valid;
`ifdef SOBEL_WIN_COORD_EN
  logic [9:0] win_x, win_y;
`endif

  int checks   = 0;
  int failures = 0;
  int mr = 0;
  int mc = 0;
  int wcount = 0;
  logic [71:0] last_obs;

  sobel_window_gen #(.bit_width(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
    .pix_in(pix_in),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .win_valid(win_valid)
`ifdef SOBEL_WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] win_now();
    return {p0, p1, p2, p3, p4, p5, p6, p7, p8};
  endfunction

  // Expected window for a pixel at (r,c) completing it: rows r-2..r, cols c-2..c
  function automatic logic [71:0] expwin(int r, int c);
    logic [71:0] e;
    e = '0;
    for (int k = 0; k < 9; k++)
      e[71 - 8*k -: 8] = 8'((((r - 2 + k / 3) & 15) << 4) | ((c - 2 + k % 3) & 15));
    return e;
  endfunction

  // Send one pixel at the model position, then check the registered result
  task automatic send(input bit fs);
    logic exp_v;
    if (fs) begin
      mr = 0;
      mc = 0;
    end
    pix_valid   = 1'b1;
    frame_start = fs;
    pix_in      = 8'(((mr & 15) << 4) | (mc & 15));
    exp_v       = (mr >= 2) && (mc >= 2);
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    last_obs    = win_now();
    chk("win_valid", 72'(win_valid), 72'(exp_v));
    if (exp_v) begin
      wcount++;
      chk("window", last_obs, expwin(mr, mc));
`ifdef SOBEL_WIN_COORD_EN
      chk("coord", {52'd0, win_y, win_x}, {52'd0, 10'(mr - 1), 10'(mc - 1)});
`endif
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // Idle cycles: no strobe and the window must hold
  task automatic bubble(input int n);
    logic [71:0] held;
    held = win_now();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("bubble_wv", 72'(win_valid), 72'd0);
      chk("bubble_hold", win_now(), held);
    end
  endtask

  task automatic frame(input bit fs, input bit bubbles);
    for (int i = 0; i < W * H; i++) begin
      send(fs && i == 0);
      if (bubbles && $urandom_range(0, 3) == 0) bubble(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_win", win_now(), 72'd0);
    chk("rst_wv", 72'(win_valid), 72'd0);
`ifdef SOBEL_WIN_COORD_EN
    chk("rst_xy", {52'd0, win_y, win_x}, 72'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scenarios 1 and 2: full frame, first and last windows by hand
    wcount = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r == 0 && c == 0);
        if (r == 2 && c == 2) begin
          chk("s1_first", last_obs, 72'h000102101112202122);
`ifdef SOBEL_WIN_COORD_EN
          chk("s1_xy", {52'd0, win_y, win_x}, {52'd0, 10'd1, 10'd1});
`endif
        end
      end
    chk("s2_last_p8p4", {56'd0, p8, p4}, {56'd0, 16'h3726});
    chk("s2_count", 72'(wcount), 72'd12);

    // Scenario 3: random bubbles
    wcount = 0;
    frame(1'b1, 1'b1);
    chk("s3_count", 72'(wcount), 72'd12);

    // Scenario 4: resync at (1,5) of a running frame
    send(1'b1);
    while (!(mr == 1 && mc == 5)) send(1'b0);
    wcount = 0;
    send(1'b1);
    for (int i = 1; i < W * H; i++) begin
      send(1'b0);
      if (mr == 2 && mc == 3) chk("s4_first", last_obs, 72'h000102101112202122);
    end
    chk("s4_count", 72'(wcount), 72'd12);

    // Scenario 5: reset mid row 2, then a frame without frame_start
    send(1'b1);
    while (!(mr == 2 && mc == 4)) send(1'b0);
    rst = 1'b1;
    #2;
    chk("s5_rst_win", win_now(), 72'd0);
    chk("s5_rst_wv", 72'(win_valid), 72'd0);
    pix_valid = 1'b1;
    pix_in    = 8'hff;
    @(posedge clk);
    #1;
    chk("s5_rst_hold", win_now(), 72'd0);
    chk("s5_rst_wv2", 72'(win_valid), 72'd0);
`ifdef SOBEL_WIN_COORD_EN
    chk("s5_rst_xy", {52'd0, win_y, win_x}, 72'd0);
`endif
    pix_valid = 1'b0;
    rst = 1'b0;
    mr = 0;
    mc = 0;
    wcount = 0;
    frame(1'b0, 1'b0);
    chk("s5_count", 72'(wcount), 72'd12);

    // Scenario 6: two back-to-back frames, second relies on row wrap
    wcount = 0;
    frame(1'b1, 1'b0);
    for (int i = 0; i < W * H; i++) begin
      send(1'b0);
      if (mr == 2 && mc == 3) chk("s6_f2_first", last_obs, 72'h000102101112202122);
    end
    chk("s6_count", 72'(wcount), 72'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
